// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared types for the register-file write path
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = $clog2(XLEN);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } mc_entry_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wq_fifo.sv
// ============================================================================
// rf_wq_fifo : multi-cycle result queue with per-entry WAW kill and busy mask
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rf_wq_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  mc_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    output logic                  full,
    output logic                  empty,
    output mc_entry_t             head,
    output logic [XLEN-1:0]       busy_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    mc_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].live <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && r_mem[i].live && (r_mem[i].addr == kill_addr)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            // Vacated slots are marked dead so busy_mask only sees occupied entries.
            if (pop) begin
                r_mem[r_head].live <= 1'b0;
                r_head             <= r_head + 1'b1;
            end
            if (push) begin
                r_mem[r_tail] <= push_entry;
                r_tail        <= r_tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_head];

    // A same-cycle kill already removes the entry from the mask.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live && !(kill_en && (r_mem[i].addr == kill_addr))) begin
                busy_mask[r_mem[i].addr] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// rf_write_arbiter : shares the RF write port between writeback and mult/div
// Revision         : 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import pipeline_pkg::*;
#(
    parameter int SIZE         = XLEN,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_we,
    input  logic [$clog2(SIZE)-1:0]  wb_addr,
    input  logic [SIZE-1:0]          wb_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [$clog2(SIZE)-1:0]  mc_addr,
    input  logic [SIZE-1:0]          mc_data,
    output logic                     rf_we,
    output logic [$clog2(SIZE)-1:0]  rf_addr,
    output logic [SIZE-1:0]          rf_data,
    output logic [SIZE-1:0]          busy_mask,
    output logic                     stall_pipe
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t               w_wb;
    logic                  w_wb_ok;
    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [STARVE_W-1:0]   r_starve;
    logic [STARVE_W-1:0]   w_starve_nxt;
    logic                  w_full;
    logic                  w_empty;
    mc_entry_t             w_head;
    mc_entry_t             w_push_entry;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_kill_en;
    logic                  w_issue;
    logic [REG_ADDR_W-1:0] w_issue_addr;
    logic [XLEN-1:0]       w_issue_data;

    assign w_wb.we   = wb_we;
    assign w_wb.addr = wb_addr;
    assign w_wb.data = wb_data;
    assign w_wb_ok   = w_wb.we && (w_wb.addr != REG_ZERO);

    assign mc_ready = !w_full;
    assign w_push   = mc_valid && !w_full;

    // A same-cycle writeback to the same register is younger, so the mc result is born dead.
    assign w_push_entry.live = (mc_addr != REG_ZERO) && !(w_kill_en && (wb_addr == mc_addr));
    assign w_push_entry.addr = mc_addr;
    assign w_push_entry.data = mc_data;

    rf_wq_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .kill_en    (w_kill_en),
        .kill_addr  (wb_addr),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head),
        .busy_mask  (busy_mask)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = '0;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_kill_en    = 1'b0;
        w_issue_addr = w_head.addr;
        w_issue_data = w_head.data;
        case (r_state)
            NORMAL: begin
                if (w_wb_ok) begin
                    w_issue      = 1'b1;
                    w_kill_en    = 1'b1;
                    w_issue_addr = wb_addr;
                    w_issue_data = wb_data;
                end else if (!w_empty) begin
                    w_pop   = 1'b1;
                    w_issue = w_head.live;
                end
                if (w_full && w_wb_ok) begin
                    w_starve_nxt = (r_starve == STARVE_W'(STARVE_LIMIT)) ? r_starve
                                                                         : r_starve + 1'b1;
                end
                if (r_starve == STARVE_W'(STARVE_LIMIT)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Writeback is dropped here; killed heads are skipped until a live one issues.
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    w_issue = w_head.live;
                    if (w_head.live) begin
                        w_state_nxt = NORMAL;
                    end
                end else begin
                    w_state_nxt = NORMAL;
                end
            end
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= NORMAL;
            r_starve <= '0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            rf_we    <= w_issue;
            if (w_issue) begin
                rf_addr <= w_issue_addr;
                rf_data <= w_issue_data;
            end
        end
    end

    assign stall_pipe = (r_state == DRAIN);

    a_no_wb_while_stalled: assert property (
        @(posedge clk) disable iff (!rst_n) (r_state == DRAIN) |-> !wb_we
    );

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// tb_rf_write_arbiter : directed plus randomized checks against a queue model
// Revision            : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rf_write_arbiter;

    localparam int SIZE         = 32;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;
    localparam int AW           = $clog2(SIZE);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_we = 1'b0;
    logic [AW-1:0]   wb_addr = '0;
    logic [SIZE-1:0] wb_data = '0;
    logic            mc_valid = 1'b0;
    logic            mc_ready;
    logic [AW-1:0]   mc_addr = '0;
    logic [SIZE-1:0] mc_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [SIZE-1:0] rf_data;
    logic [SIZE-1:0] busy_mask;
    logic            stall_pipe;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .SIZE         (SIZE),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .busy_mask  (busy_mask),
        .stall_pipe (stall_pipe)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending mc results in program order, plus the visible port state.
    typedef struct packed {
        logic            live;
        logic [AW-1:0]   addr;
        logic [SIZE-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [SIZE-1:0] m_data = '0;
    logic            m_stall = 1'b0;
    int              m_starve = 0;

    function automatic logic [SIZE-1:0] exp_busy();
        logic [SIZE-1:0] b = '0;
        logic wb_kills = wb_we && (wb_addr != 0) && !m_stall;
        foreach (mq[i]) begin
            if (mq[i].live && !(wb_kills && mq[i].addr == wb_addr)) b[mq[i].addr] = 1'b1;
        end
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic model_step();
        bit   accept, full, wb_ok, wb_wrote, nxt_stall;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_stall = 1'b0; m_starve = 0;
            return;
        end
        accept   = mc_valid && (mq.size() < DEPTH);
        full     = (mq.size() == DEPTH);
        wb_ok    = wb_we && (wb_addr != 0);
        wb_wrote = 1'b0;
        m_we     = 1'b0;
        if (m_stall) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    m_we = 1'b1; m_addr = e.addr; m_data = e.data;
                    m_stall = 1'b0;
                end
            end else begin
                m_stall = 1'b0;
            end
            m_starve = 0;
        end else begin
            nxt_stall = (m_starve >= STARVE_LIMIT);
            if (wb_ok) begin
                m_we = 1'b1; m_addr = wb_addr; m_data = wb_data;
                wb_wrote = 1'b1;
                foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    m_we = 1'b1; m_addr = e.addr; m_data = e.data;
                end
            end
            if (full && wb_ok) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else               m_starve = 0;
            m_stall = nxt_stall;
        end
        if (accept) begin
            e.live = (mc_addr != 0) && !(wb_wrote && wb_addr == mc_addr);
            e.addr = mc_addr;
            e.data = mc_data;
            mq.push_back(e);
        end
    endtask

    task automatic apply(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [SIZE-1:0] wd, input logic mv,
                         input logic [AW-1:0] ma, input logic [SIZE-1:0] md);
        @(negedge clk);
        rst_n = r; wb_we = we; wb_addr = wa; wb_data = wd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        #1;
        if (checking) begin
            check_eq("rf_we",      32'(rf_we),      32'(m_we));
            check_eq("rf_addr",    32'(rf_addr),    32'(m_addr));
            check_eq("rf_data",    rf_data,         m_data);
            check_eq("stall_pipe", 32'(stall_pipe), 32'(m_stall));
            check_eq("mc_ready",   32'(mc_ready),   32'(mq.size() < DEPTH));
            check_eq("busy_mask",  busy_mask,       exp_busy());
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [SIZE-1:0] wd,
                        input logic mv, input logic [AW-1:0] ma, input logic [SIZE-1:0] md);
        apply(1'b1, we, wa, wd, mv, ma, md);
        tick();
    endtask

    initial begin
        apply(1'b0, 0, 0, 0, 0, 0, 0); tick();
        apply(1'b0, 0, 0, 0, 0, 0, 0); tick();
        checking = 1'b1;
        check_eq("reset_rf_we",   32'(rf_we),      32'd0);
        check_eq("reset_rf_addr", 32'(rf_addr),    32'd0);
        check_eq("reset_rf_data", rf_data,         32'd0);
        check_eq("reset_stall",   32'(stall_pipe), 32'd0);
        check_eq("reset_ready",   32'(mc_ready),   32'd1);
        check_eq("reset_busy",    busy_mask,       32'd0);

        // Reset with a queued entry discards it.
        step(0, 0, 0, 1, 5, 32'hA5A5_A5A5);
        apply(1'b0, 0, 0, 0, 0, 0, 0); tick();
        check_eq("midrst_we",    32'(rf_we),    32'd0);
        check_eq("midrst_busy",  busy_mask,     32'd0);
        check_eq("midrst_ready", 32'(mc_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("midrst_no_r5", 32'(rf_we), 32'd0);

        // Basic drain.
        step(0, 0, 0, 1, 3, 32'h11);
        check_eq("drain_busy3_set", 32'(busy_mask[3]), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("drain_we",         32'(rf_we),        32'd1);
        check_eq("drain_addr",       32'(rf_addr),      32'd3);
        check_eq("drain_data",       rf_data,           32'h11);
        check_eq("drain_busy3_clr",  32'(busy_mask[3]), 32'd0);

        // Writeback priority over a queued result.
        step(0, 0, 0, 1, 4, 32'h22);
        step(1, 7, 32'h33, 0, 0, 0);
        check_eq("prio_addr1",  32'(rf_addr),  32'd7);
        check_eq("prio_data1",  rf_data,       32'h33);
        check_eq("prio_ready",  32'(mc_ready), 32'd1);
        step(1, 7, 32'h33, 0, 0, 0);
        check_eq("prio_addr2",  32'(rf_addr),  32'd7);
        step(0, 0, 0, 0, 0, 0);
        check_eq("prio_we3",    32'(rf_we),    32'd1);
        check_eq("prio_addr3",  32'(rf_addr),  32'd4);
        check_eq("prio_data3",  rf_data,       32'h22);

        // WAW kill of a queued entry.
        step(0, 0, 0, 1, 9, 32'h44);
        apply(1'b1, 1, 9, 32'h55, 0, 0, 0);
        check_eq("waw_busy9_kill", 32'(busy_mask[9]), 32'd0);
        tick();
        check_eq("waw_addr", 32'(rf_addr), 32'd9);
        check_eq("waw_data", rf_data,      32'h55);
        step(0, 0, 0, 0, 0, 0);
        check_eq("waw_silent_pop", 32'(rf_we), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("waw_idle", 32'(rf_we), 32'd0);

        // r0 suppression and same-cycle wb/mc conflict.
        step(0, 0, 0, 1, 0, 32'h66);
        step(0, 0, 0, 0, 0, 0);
        check_eq("r0_no_write", 32'(rf_we), 32'd0);
        step(1, 6, 32'h77, 1, 6, 32'h88);
        check_eq("conf_addr", 32'(rf_addr), 32'd6);
        check_eq("conf_data", rf_data,      32'h77);
        check_eq("conf_busy_none", busy_mask, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("conf_no_88", 32'(rf_we), 32'd0);

        // Starvation: fill the queue under continuous writeback traffic.
        step(1, 1, 32'h100, 1, 10, 32'hA10);
        step(1, 1, 32'h101, 1, 11, 32'hA11);
        check_eq("starve_full_ready", 32'(mc_ready), 32'd0);
        for (int i = 0; i < STARVE_LIMIT; i++) step(1, 1, 32'h200 + i, 0, 0, 0);
        check_eq("starve_not_yet", 32'(stall_pipe), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("starve_stall",   32'(stall_pipe), 32'd1);
        check_eq("starve_head1",   32'(rf_addr),    32'd10);
        step(0, 0, 0, 0, 0, 0);
        check_eq("starve_head2",   32'(rf_addr),    32'd11);
        check_eq("starve_data2",   rf_data,         32'hA11);
        check_eq("starve_release", 32'(stall_pipe), 32'd0);

        // Randomized traffic with alternating light/heavy writeback load.
        for (int i = 0; i < 1200; i++) begin
            int   wbp;
            logic r, we, mv;
            wbp = ((i / 150) % 2 == 1) ? 95 : 45;
            r   = ($urandom_range(199) != 0);
            we  = !m_stall && ($urandom_range(99) < wbp);
            mv  = ($urandom_range(99) < 60);
            apply(r, we, AW'($urandom_range(15)), $urandom, mv, AW'($urandom_range(15)), $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
